context_switch_scheduler: RTL and testbench
===========================================

// Module: context_switch_scheduler
// PURPOSE
//  Consumes the quantum counter's troca_contexto / intrucaoIOContexto / pc_processo_trocado outputs plus fimProcesso.
//  Keeps a per-process table (state + saved PC) and picks the next process round-robin.
//  Redirects the PC through pc_load/pc_novo and drives processo_atual back to the quantum counter.
//  Slot 0 is the OS (SO); it runs whenever no user process is READY.
// PARAMETERS
//  MAX_PROC     4      table slots incl. SO slot 0; power of 2, >=2
//  PC_W         32     PC width
//  SO_ENTRY_PC  32'd0  PC at which the SO is (re)entered
//  PID_W        $clog2(MAX_PROC)  derived, not overridable
// PORTS
//  clock               in   1      rising-edge clock
//  reset               in   1      asynchronous, active-low
//  troca_contexto      in   1      quantum expired (level, may stay high)
//  intrucaoIOContexto  in   1      current process issued I/O -> block it
//  fimProcesso         in   1      current process finished
//  pc_processo_trocado in   PC_W   resume PC of interrupted process
//  proc_create         in   1      1-cycle request: load new process
//  proc_create_pc      in   PC_W   start PC of new process
//  io_done             in   1      1-cycle: I/O of io_done_pid complete
//  io_done_pid         in   PID_W  process whose I/O completed
//  processo_atual      out  PID_W  running process id (0 = SO)
//  pc_novo             out  PC_W   PC to load
//  pc_load             out  1      1-cycle pulse: PC <= pc_novo
//  sched_busy          out  1      high in SAVE/SELECT/DISPATCH
//  create_ok           out  1      1-cycle pulse, cycle after proc_create, slot allocated
//  create_full         out  1      1-cycle pulse, cycle after proc_create, no FREE slot
//  create_pid          out  PID_W  slot allocated (valid with create_ok)
// BEHAVIOUR
//  Reset (async, reset=0)
//   - All slots FREE except slot 0 = RUNNING.
//   - processo_atual=0, pc_novo=SO_ENTRY_PC; pc_load, sched_busy, create_ok, create_full = 0; create_pid=0.
//   - Edge registers cleared. FSM = RUN. Asserting reset mid-switch aborts it; no partial table write survives.
//  Slot states: FREE, READY, RUNNING, BLOCKED. Exactly one slot is RUNNING outside SAVE/SELECT.
//  Event detect: each event input is registered; an event = 0->1 transition seen in RUN.
//   - Edges in other states, or while processo_atual==0, are dropped.
//   - Same-cycle priority: fimProcesso > intrucaoIOContexto > troca_contexto.
//  FSM
//   - RUN:
//     * event -> SAVE, latching the cause.
//     * No event, processo_atual==0 and any slot>=1 READY -> SELECT (SO yields).
//   - SAVE (1 cycle), current slot:
//     * fim -> FREE, PC not stored.
//     * IO -> BLOCKED, PC <= pc_processo_trocado.
//     * troca -> READY, PC <= pc_processo_trocado.
//   - SELECT (1 cycle): scan slots 1..MAX_PROC-1 starting at (current+1) mod MAX_PROC, wrapping, skipping 0.
//     * First READY wins. The just-preempted process is eligible, so it is chosen only if it is the sole READY one.
//     * None READY -> target = SO, PC = SO_ENTRY_PC.
//   - DISPATCH (1 cycle): pc_novo <= target PC, processo_atual <= target, pc_load=1, target slot RUNNING -> RUN.
//  Latency: event edge registered at cycle N -> pc_load high in cycle N+3; processo_atual updates in that same cycle.
//  Creation (any FSM state)
//   - Lowest-index FREE slot >=1 -> READY, PC <= proc_create_pc; create_ok + create_pid next cycle.
//   - No FREE slot -> create_full; table unchanged.
//   - Sees table state before a same-cycle SAVE, so a slot freed in that cycle is not reused until the next cycle.
//  io_done: slot io_done_pid BLOCKED -> READY. Ignored if the slot is not BLOCKED, or if pid==0.
//   - Applies in the same cycle as a SAVE of a different slot; SAVE and io_done never target the same slot.
//  Arithmetic: PIDs wrap modulo MAX_PROC; no PC arithmetic here, PC+1 is done upstream.
// TESTING
//  1. Reset; proc_create pc=0x40 -> create_ok, create_pid=1; 3 cycles later pc_load, pc_novo=0x40, processo_atual=1.
//  2. Pids 1,2 READY, 1 running; troca_contexto rise with saved pc=0x45 -> pc_load at N+3 to pid 2; slot1 READY pc=0x45.
//  3. Pid 1 only: intrucaoIOContexto rise -> SO dispatched, pc_novo=SO_ENTRY_PC; io_done pid1 -> pid1 resumes at saved PC.
//  4. fimProcesso and troca_contexto rise together -> slot freed, PC not saved; next READY dispatched.
//  5. Fill slots 1..3, fourth proc_create -> create_full=1, create_ok=0; troca_contexto held high 5 cycles -> exactly one switch.
//  6. reset=0 in SELECT -> outputs at reset values immediately; after release, pc_load stays 0 and slot 0 RUNNING.

Source files
------------

// File: rtl/context_switch_scheduler.sv
// Context-switch scheduler: per-process table (state + saved PC), round-robin pick of the
// next READY process and PC redirect. Slot 0 is the OS and runs whenever no user process is READY.
module context_switch_scheduler #(
  parameter int              MAX_PROC    = 4,
  parameter int              PC_W        = 32,
  parameter logic [PC_W-1:0] SO_ENTRY_PC = '0,
  localparam int             PID_W       = $clog2(MAX_PROC)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             troca_contexto,
  input  logic             intrucaoIOContexto,
  input  logic             fimProcesso,
  input  logic [PC_W-1:0]  pc_processo_trocado,
  input  logic             proc_create,
  input  logic [PC_W-1:0]  proc_create_pc,
  input  logic             io_done,
  input  logic [PID_W-1:0] io_done_pid,
  output logic [PID_W-1:0] processo_atual,
  output logic [PC_W-1:0]  pc_novo,
  output logic             pc_load,
  output logic             sched_busy,
  output logic             create_ok,
  output logic             create_full,
  output logic [PID_W-1:0] create_pid
);

  // state    | meaning
  // RUN      | current process executes; watch for events / SO yield
  // SAVE     | store cause into the current slot (state + resume PC)
  // SELECT   | round-robin scan for the next READY slot, load target
  // DISPATCH | pc_load pulse towards the fetch stage
  typedef enum logic [1:0] {S_RUN, S_SAVE, S_SELECT, S_DISPATCH} fsm_t;
  typedef enum logic [1:0] {SL_FREE, SL_READY, SL_RUNNING, SL_BLOCKED} slot_st_t;
  typedef enum logic [1:0] {C_TROCA, C_IO, C_FIM} cause_t;

  fsm_t                 fsm_q, fsm_d;
  cause_t               cause_q, cause_d;
  slot_st_t             slot_st_q [MAX_PROC];
  slot_st_t             slot_st_d [MAX_PROC];
  logic [PC_W-1:0]      slot_pc_q [MAX_PROC];
  logic [PC_W-1:0]      slot_pc_d [MAX_PROC];
  logic [PID_W-1:0]     cur_q, cur_d;
  logic [PC_W-1:0]      pc_novo_q, pc_novo_d;
  logic                 pc_load_q, pc_load_d;
  logic                 create_ok_q, create_ok_d;
  logic                 create_full_q, create_full_d;
  logic [PID_W-1:0]     create_pid_q, create_pid_d;

  logic                 fim_r_q, fim_p_q;
  logic                 io_r_q, io_p_q;
  logic                 troca_r_q, troca_p_q;

  logic                 fim_edge, io_edge, troca_edge, event_any;
  logic                 user_ready;
  logic                 sel_found;
  logic [PID_W-1:0]     sel_pid;
  logic [PID_W-1:0]     scan_idx;
  logic                 free_found;
  logic [PID_W-1:0]     free_pid;

  assign fim_edge   = fim_r_q   & ~fim_p_q;
  assign io_edge    = io_r_q    & ~io_p_q;
  assign troca_edge = troca_r_q & ~troca_p_q;
  // Edges outside RUN or while the SO runs are simply lost.
  assign event_any  = (fsm_q == S_RUN) && (cur_q != '0) &&
                      (fim_edge || io_edge || troca_edge);

  always_comb begin
    user_ready = 1'b0;
    for (int k = 1; k < MAX_PROC; k++) begin
      if (slot_st_q[k] == SL_READY) user_ready = 1'b1;
    end
  end

  // Scan starts after the current slot; the last probe lands on the current slot itself.
  always_comb begin
    sel_found = 1'b0;
    sel_pid   = '0;
    scan_idx  = '0;
    for (int j = 0; j < MAX_PROC; j++) begin
      scan_idx = cur_q + PID_W'(j + 1);
      if (!sel_found && (scan_idx != '0) && (slot_st_q[scan_idx] == SL_READY)) begin
        sel_found = 1'b1;
        sel_pid   = scan_idx;
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_pid   = '0;
    for (int k = MAX_PROC - 1; k >= 1; k--) begin
      if (slot_st_q[k] == SL_FREE) begin
        free_found = 1'b1;
        free_pid   = PID_W'(k);
      end
    end
  end

  always_comb begin
    fsm_d         = fsm_q;
    cause_d       = cause_q;
    cur_d         = cur_q;
    pc_novo_d     = pc_novo_q;
    pc_load_d     = 1'b0;
    create_ok_d   = 1'b0;
    create_full_d = 1'b0;
    create_pid_d  = create_pid_q;
    slot_st_d     = slot_st_q;
    slot_pc_d     = slot_pc_q;

    case (fsm_q)
      S_RUN: begin
        if (event_any) begin
          fsm_d = S_SAVE;
          if (fim_edge)     cause_d = C_FIM;
          else if (io_edge) cause_d = C_IO;
          else              cause_d = C_TROCA;
        end else if ((cur_q == '0) && user_ready) begin
          fsm_d = S_SELECT;
        end
      end
      S_SAVE: begin
        fsm_d = S_SELECT;
        case (cause_q)
          C_FIM: slot_st_d[cur_q] = SL_FREE;
          C_IO: begin
            slot_st_d[cur_q] = SL_BLOCKED;
            slot_pc_d[cur_q] = pc_processo_trocado;
          end
          default: begin
            slot_st_d[cur_q] = SL_READY;
            slot_pc_d[cur_q] = pc_processo_trocado;
          end
        endcase
      end
      S_SELECT: begin
        fsm_d     = S_DISPATCH;
        pc_load_d = 1'b1;
        // A yielding SO leaves RUNNING so only the dispatched slot holds it.
        if (cur_q == '0) slot_st_d[0] = SL_READY;
        if (sel_found) begin
          cur_d              = sel_pid;
          pc_novo_d          = slot_pc_q[sel_pid];
          slot_st_d[sel_pid] = SL_RUNNING;
        end else begin
          cur_d        = '0;
          pc_novo_d    = SO_ENTRY_PC;
          slot_st_d[0] = SL_RUNNING;
        end
      end
      default: fsm_d = S_RUN;
    endcase

    if (io_done && (io_done_pid != '0) && (slot_st_q[io_done_pid] == SL_BLOCKED)) begin
      slot_st_d[io_done_pid] = SL_READY;
    end

    // Works on the pre-SAVE table, so a slot freed this cycle is reused only later.
    if (proc_create) begin
      if (free_found) begin
        slot_st_d[free_pid] = SL_READY;
        slot_pc_d[free_pid] = proc_create_pc;
        create_ok_d         = 1'b1;
        create_pid_d        = free_pid;
      end else begin
        create_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm_q         <= S_RUN;
      cause_q       <= C_TROCA;
      cur_q         <= '0;
      pc_novo_q     <= SO_ENTRY_PC;
      pc_load_q     <= 1'b0;
      create_ok_q   <= 1'b0;
      create_full_q <= 1'b0;
      create_pid_q  <= '0;
      for (int k = 0; k < MAX_PROC; k++) begin
        slot_st_q[k] <= (k == 0) ? SL_RUNNING : SL_FREE;
        slot_pc_q[k] <= '0;
      end
      fim_r_q   <= 1'b0;
      fim_p_q   <= 1'b0;
      io_r_q    <= 1'b0;
      io_p_q    <= 1'b0;
      troca_r_q <= 1'b0;
      troca_p_q <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      cause_q       <= cause_d;
      cur_q         <= cur_d;
      pc_novo_q     <= pc_novo_d;
      pc_load_q     <= pc_load_d;
      create_ok_q   <= create_ok_d;
      create_full_q <= create_full_d;
      create_pid_q  <= create_pid_d;
      slot_st_q     <= slot_st_d;
      slot_pc_q     <= slot_pc_d;
      fim_r_q       <= fimProcesso;
      fim_p_q       <= fim_r_q;
      io_r_q        <= intrucaoIOContexto;
      io_p_q        <= io_r_q;
      troca_r_q     <= troca_contexto;
      troca_p_q     <= troca_r_q;
    end
  end

  assign processo_atual = cur_q;
  assign pc_novo        = pc_novo_q;
  assign pc_load        = pc_load_q;
  assign sched_busy     = (fsm_q != S_RUN);
  assign create_ok      = create_ok_q;
  assign create_full    = create_full_q;
  assign create_pid     = create_pid_q;

endmodule

// File: tb/tb_context_switch_scheduler.sv
// Bench for context_switch_scheduler: directed scenarios then random operations, each checked
// against a transaction-level model of the process table and round-robin choice.
module tb_context_switch_scheduler;

  localparam int          NP    = 4;
  localparam logic [31:0] SO_PC = 32'h0000_0100;
  localparam int          FREE = 0, READY = 1, RUNNING = 2, BLOCKED = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        troca_contexto = 1'b0, intrucaoIOContexto = 1'b0, fimProcesso = 1'b0;
  logic [31:0] pc_processo_trocado = '0;
  logic        proc_create = 1'b0;
  logic [31:0] proc_create_pc = '0;
  logic        io_done = 1'b0;
  logic [1:0]  io_done_pid = '0;
  logic [1:0]  processo_atual;
  logic [31:0] pc_novo;
  logic        pc_load, sched_busy, create_ok, create_full;
  logic [1:0]  create_pid;

  context_switch_scheduler #(.MAX_PROC(NP), .PC_W(32), .SO_ENTRY_PC(SO_PC)) dut (
    .clock(clock), .reset(reset),
    .troca_contexto(troca_contexto), .intrucaoIOContexto(intrucaoIOContexto),
    .fimProcesso(fimProcesso), .pc_processo_trocado(pc_processo_trocado),
    .proc_create(proc_create), .proc_create_pc(proc_create_pc),
    .io_done(io_done), .io_done_pid(io_done_pid),
    .processo_atual(processo_atual), .pc_novo(pc_novo), .pc_load(pc_load),
    .sched_busy(sched_busy), .create_ok(create_ok), .create_full(create_full),
    .create_pid(create_pid)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one state and one saved PC per process, plus the running pid.
  int          m_st [NP];
  logic [31:0] m_pc [NP];
  int          m_cur;

  // Observation of one operation window.
  int          w_pulses, w_first;
  logic [31:0] w_pc;
  logic [1:0]  w_pid;
  logic        w_busy2, w_ok, w_full;
  logic [1:0]  w_cpid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NP; k++) begin
      m_st[k] = FREE;
      m_pc[k] = '0;
    end
    m_st[0] = RUNNING;
    m_cur   = 0;
  endfunction

  function automatic int pick();
    for (int k = 1; k <= NP; k++) begin
      int idx = (m_cur + k) % NP;
      if (idx != 0 && m_st[idx] == READY) return idx;
    end
    return 0;
  endfunction

  function automatic bit any_ready();
    for (int k = 1; k < NP; k++) if (m_st[k] == READY) return 1'b1;
    return 1'b0;
  endfunction

  // Runs 8 cycles after stimulus was applied on a falling edge; pulses drop after cycle 1,
  // event inputs after cycle 'hold'.
  task automatic window(input int hold);
    w_pulses = 0; w_first = 0; w_pc = '0; w_pid = '0; w_busy2 = 1'b0;
    w_ok = 1'b0; w_full = 1'b0; w_cpid = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock); #1;
      if (i == 1) begin
        w_ok = create_ok; w_full = create_full; w_cpid = create_pid;
        proc_create = 1'b0; io_done = 1'b0;
      end
      if (i == 2) w_busy2 = sched_busy;
      if (pc_load) begin
        if (w_pulses == 0) begin
          w_first = i; w_pc = pc_novo; w_pid = processo_atual;
        end
        w_pulses++;
      end
      if (i == hold) begin
        troca_contexto = 1'b0; intrucaoIOContexto = 1'b0; fimProcesso = 1'b0;
      end
    end
  endtask

  task automatic expect_dispatch(input string tag, input bit exp_disp, input int at);
    if (exp_disp) begin
      int t;
      logic [31:0] epc;
      t   = pick();
      epc = (t == 0) ? SO_PC : m_pc[t];
      if (t != 0) m_st[t] = RUNNING;
      m_cur = t;
      chk({tag, "_pulses"}, w_pulses, 1);
      chk({tag, "_latency"}, w_first, at);
      chk({tag, "_pc_novo"}, w_pc, epc);
      chk({tag, "_pid"}, w_pid, t);
    end else begin
      chk({tag, "_no_pulse"}, w_pulses, 0);
      chk({tag, "_pid_hold"}, processo_atual, m_cur);
    end
  endtask

  task automatic op_create(input string tag, input logic [31:0] pc);
    int fs;
    bit was_so;
    @(negedge clock);
    proc_create = 1'b1; proc_create_pc = pc;
    window(1);
    fs = 0;
    for (int k = NP - 1; k >= 1; k--) if (m_st[k] == FREE) fs = k;
    chk({tag, "_ok"}, w_ok, fs != 0);
    chk({tag, "_full"}, w_full, fs == 0);
    if (fs != 0) begin
      chk({tag, "_cpid"}, w_cpid, fs);
      m_st[fs] = READY;
      m_pc[fs] = pc;
    end
    was_so = (m_cur == 0);
    expect_dispatch(tag, was_so && any_ready(), 3);
  endtask

  // mask = {fim, io, troca}
  task automatic op_event(input string tag, input logic [2:0] mask, input logic [31:0] pc,
                          input int hold);
    @(negedge clock);
    fimProcesso = mask[2]; intrucaoIOContexto = mask[1]; troca_contexto = mask[0];
    pc_processo_trocado = pc;
    window(hold);
    if (m_cur != 0) begin
      if (mask[2]) m_st[m_cur] = FREE;
      else if (mask[1]) begin m_st[m_cur] = BLOCKED; m_pc[m_cur] = pc; end
      else begin m_st[m_cur] = READY; m_pc[m_cur] = pc; end
      chk({tag, "_busy"}, w_busy2, 1'b1);
      expect_dispatch(tag, 1'b1, 4);
    end else begin
      expect_dispatch(tag, 1'b0, 0);
    end
  endtask

  task automatic op_io_done(input string tag, input logic [1:0] pid);
    @(negedge clock);
    io_done = 1'b1; io_done_pid = pid;
    window(1);
    if (pid != 0 && m_st[pid] == BLOCKED) m_st[pid] = READY;
    expect_dispatch(tag, (m_cur == 0) && any_ready(), 3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    model_reset();
    #12;
    chk("rst_pid", processo_atual, 0);
    chk("rst_pc_novo", pc_novo, SO_PC);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_busy", sched_busy, 0);
    chk("rst_create_ok", create_ok, 0);
    chk("rst_create_full", create_full, 0);
    chk("rst_create_pid", create_pid, 0);
    @(negedge clock);
    reset = 1'b1;

    op_create("t1_create", 32'h40);
    op_create("t2_create", 32'h80);
    op_event("t2_troca", 3'b001, 32'h45, 1);
    op_event("t2_back", 3'b001, 32'h85, 2);
    op_event("t3_fim1", 3'b100, 32'hdead, 1);
    op_event("t3_io", 3'b010, 32'h99, 3);
    op_event("t3_so_drop", 3'b001, 32'h11, 1);
    op_io_done("t3_io_done", 2'd2);
    op_create("t4_create", 32'h200);
    op_event("t4_fim_troca", 3'b101, 32'hbeef, 2);
    op_create("t5_c2", 32'h300);
    op_create("t5_c3", 32'h400);
    op_create("t5_full", 32'h500);
    op_event("t5_hold", 3'b001, 32'h210, 5);
    op_io_done("t5_io_ignored", 2'd3);

    @(negedge clock);
    troca_contexto = 1'b1; pc_processo_trocado = 32'h777;
    repeat (3) @(posedge clock);
    #1;
    chk("t6_in_select", sched_busy, 1);
    chk("t6_no_load_yet", pc_load, 0);
    reset = 1'b0;
    #1;
    chk("t6_rst_pid", processo_atual, 0);
    chk("t6_rst_pc_novo", pc_novo, SO_PC);
    chk("t6_rst_pc_load", pc_load, 0);
    chk("t6_rst_busy", sched_busy, 0);
    troca_contexto = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (pc_load) cnt++;
    end
    chk("t6_no_pulse", cnt, 0);
    chk("t6_pid_so", processo_atual, 0);
    op_create("t6_table_clear", 32'h600);

    for (int n = 0; n < 90; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 2)
        op_create("rnd_create", $urandom);
      else if (r <= 6)
        op_event("rnd_event", 3'($urandom_range(1, 7)), $urandom, $urandom_range(1, 5));
      else
        op_io_done("rnd_io_done", 2'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
